mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have EX/MEM-side inputs: mem_read in 1; mem_write in 1; mem_size in 2 (00 byte, 01 half, 10 word, 11 word); mem_unsigned in 1; alu_result in 32 (address or ALU value); store_data in 32; dst in 5; reg_write in 1; mem_to_reg in 1.
REQ-003 SHALL have MEM/WB-side outputs: reg_write_out out 1; mem_to_reg_out out 1; alu_result_out out 32; data_load out 32; dst_out out 5; stall out 1, which tells upstream to hold; addr_err out 1, misaligned access.
REQ-004 SHALL have data memory bus ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_be out 4; dmem_wdata out 32; dmem_rdata in 32; dmem_ack in 1.

Function
REQ-005 SHALL pass alu_result, dst and mem_to_reg through combinationally to alu_result_out, dst_out and mem_to_reg_out.
REQ-006 SHALL drive reg_write_out = reg_write & ~addr_err.
REQ-007 SHALL define a memory op as mem_read|mem_write; if both are set, the op is a write.
REQ-008 SHALL assert addr_err combinationally when a memory op is misaligned: half with alu_result[0]=1, or word with alu_result[1:0]!=0; a misaligned op issues no bus access and no stall.
REQ-009 SHALL implement FSM IDLE/ACCESS/DONE.
REQ-010 IDLE: an aligned memory op -> ACCESS; otherwise stay in IDLE.
REQ-011 ACCESS: dmem_ack=1 -> DONE; otherwise stay in ACCESS.
REQ-012 DONE: -> IDLE unconditionally, without restarting even though the inputs are still held.
REQ-013 SHALL drive stall=1 in IDLE with an aligned memory op pending, and stall=1 in ACCESS; stall SHALL be 0 in DONE and for non-memory ops.
REQ-014 SHALL assert dmem_req only in ACCESS, holding dmem_we/addr/be/wdata stable until ack; dmem_req SHALL deassert the cycle after ack.
REQ-015 SHALL drive dmem_addr = {alu_result[31:2], 2'b00}.
REQ-016 SHALL ignore dmem_ack outside ACCESS.
REQ-017 Store steering, byte: wdata = {4{store_data[7:0]}}; be = 0001 shifted left by alu_result[1:0].
REQ-018 Store steering, half: wdata = {2{store_data[15:0]}}; be = 1100 if alu_result[1]=1, else 0011.
REQ-019 Store steering, word: wdata = store_data; be = 1111.
REQ-020 On ack of a read, SHALL capture the lane selected by alu_result[1:0], then zero-extend it if mem_unsigned=1 or sign-extend it otherwise, into register data_load.
REQ-021 data_load SHALL hold its value until the next read ack; writes SHALL leave it unchanged.
REQ-022 Minimum memory-op latency SHALL be 2 stall cycles (zero-wait ack); each wait cycle SHALL add one stall cycle.

Reset
REQ-023 rst_n=0 SHALL immediately force: state IDLE, dmem_req 0, data_load 0.
REQ-024 A reset during ACCESS SHALL abandon the access; an ack arriving after reset SHALL be ignored.
REQ-025 With reset deasserted and no memory op, all outputs SHALL be pass-through values or 0.

Structure
REQ-026 Package pipeline_pkg SHALL hold the mem_size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
REQ-027 Lane extraction and extension SHALL be a sub-module load_align with inputs rdata, addr[1:0], size, unsigned and output data.
REQ-028 The block SHALL feed the MEM/WB latch directly; that latch SHALL capture its outputs on the edge leaving DONE.

Verification
REQ-029 Word store: addr 0x100, data 0xDEADBEEF, ack on first ACCESS cycle -> be 1111, wdata 0xDEADBEEF, stall high 2 cycles.
REQ-030 Byte load, signed: addr 0x103, rdata 0x80FF_0000 -> data_load 0xFFFFFF80; same access with unsigned -> 0x00000080.
REQ-031 Half load: addr 0x202, rdata 0x1234_5678, 3 wait cycles -> data_load 0x00001234, stall high 5 cycles, req deasserts after ack.
REQ-032 Misaligned word load at addr 0x101 -> addr_err 1, reg_write_out 0, stall 0, no dmem_req.
REQ-033 rst_n low during ACCESS, then late ack -> state IDLE, dmem_req 0, data_load 0, no state change on the ack.
REQ-034 Non-memory op with alu_result 0x55 -> alu_result_out 0x55, stall 0, no dmem_req.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline memory stage: access-size codes and
// the encoding of the memory access FSM.
package pipeline_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word lane out of a read word and extends it
// to 32 bits (zero-extend when i_unsigned, sign-extend otherwise).
module load_align
    import pipeline_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one data-memory bus access per aligned load or
// store, stalls upstream until it completes, and aligns load data.
//
// Bus handshake: dmem_req is high only in ACCESS and we/addr/be/wdata are held
// stable while it is high; the access completes on the rising edge where
// dmem_req && dmem_ack, after which dmem_req drops for at least one cycle.
module mem_stage
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  dst,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] data_load,
    output logic [4:0]  dst_out,
    output logic        stall,
    output logic        addr_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output state_t      dbg_state
);

    state_t      r_state;
    state_t      w_next;
    logic        w_mem_op;
    logic        w_misalign;
    logic        w_aligned_op;
    logic        w_stall;
    logic        w_req;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic [31:0] r_data_load;

    assign w_mem_op     = mem_read | mem_write;
    assign w_misalign   = ((mem_size == SZ_HALF) & alu_result[0]) |
                          (mem_size[1] & (|alu_result[1:0]));
    assign w_aligned_op = w_mem_op & ~w_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_req   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_aligned_op) begin
                    w_next  = ST_ACCESS;
                    w_stall = 1'b1;
                end
            end
            ST_ACCESS: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                if (dmem_ack) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data;
        case (mem_size)
            SZ_BYTE: begin
                w_wdata = {4{store_data[7:0]}};
                w_be    = 4'b0001 << alu_result[1:0];
            end
            SZ_HALF: begin
                w_wdata = {2{store_data[15:0]}};
                w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = store_data;
                w_be    = 4'b1111;
            end
        endcase
    end

    load_align u_load_align (
        .i_rdata    (dmem_rdata),
        .i_addr     (alu_result[1:0]),
        .i_size     (mem_size),
        .i_unsigned (mem_unsigned),
        .o_data     (w_load_data)
    );

    // A simultaneous read+write is a write, so it never updates the load register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_load <= 32'd0;
        end else if ((r_state == ST_ACCESS) && dmem_ack && mem_read && !mem_write) begin
            r_data_load <= w_load_data;
        end
    end

    assign alu_result_out = alu_result;
    assign dst_out        = dst;
    assign mem_to_reg_out = mem_to_reg;
    assign addr_err       = w_mem_op & w_misalign;
    assign reg_write_out  = reg_write & ~addr_err;
    assign stall          = w_stall;
    assign data_load      = r_data_load;
    assign dmem_req       = w_req;
    assign dmem_we        = w_req & mem_write;
    assign dmem_addr      = w_req ? {alu_result[31:2], 2'b00} : 32'd0;
    assign dmem_be        = w_req ? w_be : 4'b0000;
    assign dmem_wdata     = w_req ? w_wdata : 32'd0;
    assign dbg_state      = r_state;

endmodule
